// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if -- raster/timing bundle between the VGA timing generator
// and its consumers.
//
// Signals:
//   pix_ce       pixel clock-enable (driven by the consumer side)
//   DrawX        current horizontal position, 0..799
//   DrawY        current vertical position, 0..524
//   blank        1 = visible pixel, 0 = porch/sync/reset
//   hs, vs       horizontal / vertical sync, active low
//   frame_start  one-cycle pulse when the position wraps to (0,0)
//   line_end     high while DrawX = 799
//
// Modports:
//   master  the timing generator (drives the raster outputs)
//   slave   the consumer (drives pix_ce, observes the raster)
interface vga_timing_gen_if;
  logic       pix_ce;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       blank;
  logic       hs;
  logic       vs;
  logic       frame_start;
  logic       line_end;

  modport master (
    input  pix_ce,
    output DrawX, DrawY, blank, hs, vs, frame_start, line_end
  );

  modport slave (
    output pix_ce,
    input  DrawX, DrawY, blank, hs, vs, frame_start, line_end
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- 640x480 @ 800x525 VGA raster timing generator.
//
// Ports:
//   vga_clk  input   pixel-domain clock, all logic on its rising edge
//   reset    input   synchronous, active-high reset
//   vif      master  vga_timing_gen_if bundle (pix_ce in; DrawX, DrawY,
//                    blank, hs, vs, frame_start, line_end out)
//
// Horizontal and vertical FSMs track the porch/sync regions. Every output is
// registered and decoded from the *next* position/state, so the flags line up
// with DrawX/DrawY in the same cycle.
//
// Build option:
//   VGA_SYNC_DELAY_EN  when defined, hs/vs get one extra pix_ce-qualified
//                      register stage to match a registered colour stage
//                      downstream; blank/frame_start/line_end are unchanged.
module vga_timing_gen (
  input  logic             vga_clk,
  input  logic             reset,
  vga_timing_gen_if.master vif
);

  // Raster geometry (boundary = first pixel/line of each region).
  localparam logic [9:0] H_FRONT_START = 10'd640;
  localparam logic [9:0] H_SYNC_START  = 10'd656;
  localparam logic [9:0] H_BACK_START  = 10'd752;
  localparam logic [9:0] H_LAST        = 10'd799;
  localparam logic [9:0] V_FRONT_START = 10'd480;
  localparam logic [9:0] V_SYNC_START  = 10'd490;
  localparam logic [9:0] V_BACK_START  = 10'd492;
  localparam logic [9:0] V_LAST        = 10'd524;

  localparam logic [1:0] H_ACTIVE = 2'd0;
  localparam logic [1:0] H_FRONT  = 2'd1;
  localparam logic [1:0] H_SYNC   = 2'd2;
  localparam logic [1:0] H_BACK   = 2'd3;

  localparam logic [1:0] V_ACTIVE = 2'd0;
  localparam logic [1:0] V_FRONT  = 2'd1;
  localparam logic [1:0] V_SYNC   = 2'd2;
  localparam logic [1:0] V_BACK   = 2'd3;

  logic [9:0] x_reg, x_next;
  logic [9:0] y_reg, y_next;
  logic [1:0] h_state_reg, h_state_next;
  logic [1:0] v_state_reg, v_state_next;
  logic       blank_reg, blank_next;
  logic       hs_reg, hs_next;
  logic       vs_reg, vs_next;
  logic       frame_start_reg, frame_start_next;
  logic       line_end_reg, line_end_next;
  logic       x_wrap, y_wrap;

  // ">=" rather than "==" so a corrupted counter still falls back into range.
  assign x_wrap = (x_reg >= H_LAST);
  assign y_wrap = (y_reg >= V_LAST);

  always_comb begin
    x_next       = x_reg;
    y_next       = y_reg;
    h_state_next = h_state_reg;
    v_state_next = v_state_reg;

    if (vif.pix_ce) begin
      if (x_wrap) begin
        x_next = 10'd0;
        y_next = y_wrap ? 10'd0 : (y_reg + 10'd1);
      end else begin
        x_next = x_reg + 10'd1;
      end

      // Horizontal region changes only when the new X lands on a boundary.
      case (x_next)
        10'd0:         h_state_next = H_ACTIVE;
        H_FRONT_START: h_state_next = H_FRONT;
        H_SYNC_START:  h_state_next = H_SYNC;
        H_BACK_START:  h_state_next = H_BACK;
        default:       h_state_next = h_state_reg;
      endcase

      // Vertical region can only change on the line wrap.
      if (x_wrap) begin
        case (y_next)
          10'd0:         v_state_next = V_ACTIVE;
          V_FRONT_START: v_state_next = V_FRONT;
          V_SYNC_START:  v_state_next = V_SYNC;
          V_BACK_START:  v_state_next = V_BACK;
          default:       v_state_next = v_state_reg;
        endcase
      end
    end
  end

  // Flags decoded from the next state so they register alongside the counters.
  assign blank_next       = (h_state_next == H_ACTIVE) && (v_state_next == V_ACTIVE);
  assign hs_next          = (h_state_next != H_SYNC);
  assign vs_next          = (v_state_next != V_SYNC);
  assign line_end_next    = (x_next == H_LAST);
  assign frame_start_next = vif.pix_ce && x_wrap && y_wrap;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      x_reg           <= 10'd0;
      y_reg           <= 10'd0;
      h_state_reg     <= H_ACTIVE;
      v_state_reg     <= V_ACTIVE;
      blank_reg       <= 1'b0;
      hs_reg          <= 1'b1;
      vs_reg          <= 1'b1;
      frame_start_reg <= 1'b0;
      line_end_reg    <= 1'b0;
    end else begin
      // Pulse output: cleared on any idle cycle.
      frame_start_reg <= frame_start_next;
      // Level outputs only move with the raster; an idle cycle holds them,
      // which keeps blank=0 after reset until the first real pixel step.
      if (vif.pix_ce) begin
        x_reg        <= x_next;
        y_reg        <= y_next;
        h_state_reg  <= h_state_next;
        v_state_reg  <= v_state_next;
        blank_reg    <= blank_next;
        hs_reg       <= hs_next;
        vs_reg       <= vs_next;
        line_end_reg <= line_end_next;
      end
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  // Extra pix_ce-qualified stage on the syncs only; idles high like the syncs.
  logic hs_dly_reg;
  logic vs_dly_reg;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hs_dly_reg <= 1'b1;
      vs_dly_reg <= 1'b1;
    end else if (vif.pix_ce) begin
      hs_dly_reg <= hs_reg;
      vs_dly_reg <= vs_reg;
    end
  end

  assign vif.hs = hs_dly_reg;
  assign vif.vs = vs_dly_reg;
`else
  assign vif.hs = hs_reg;
  assign vif.vs = vs_reg;
`endif

  assign vif.DrawX       = x_reg;
  assign vif.DrawY       = y_reg;
  assign vif.blank       = blank_reg;
  assign vif.frame_start = frame_start_reg;
  assign vif.line_end    = line_end_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen -- directed self-checking bench for vga_timing_gen.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// after each rising edge. Expected values are hand-computed constants from the
// 800x525 raster geometry; hs expectations adjust when VGA_SYNC_DELAY_EN is set.
module tb_vga_timing_gen;

  logic vga_clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   fs_count;
  int   vs_low;

`ifdef VGA_SYNC_DELAY_EN
  localparam bit SYNC_DLY = 1'b1;
`else
  localparam bit SYNC_DLY = 1'b0;
`endif

  vga_timing_gen_if vif ();

  vga_timing_gen dut (
    .vga_clk (vga_clk),
    .reset   (reset),
    .vif     (vif)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic tick(input logic ce);
    vif.pix_ce = ce;
    @(posedge vga_clk);
    @(negedge vga_clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b1);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
      $display("check %s observed=%0d expected=%0d ok", tag, obs, exp_v);
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  initial begin
    reset      = 1'b1;
    vif.pix_ce = 1'b1;
    tick(1'b1);
    tick(1'b1);

    // Reset state, with pix_ce=1 showing reset wins.
    chk("rst_x",  vif.DrawX, 0);
    chk("rst_y",  vif.DrawY, 0);
    chk("rst_blank", vif.blank, 0);
    chk("rst_hs", vif.hs, 1);
    chk("rst_vs", vif.vs, 1);
    chk("rst_fs", vif.frame_start, 0);
    chk("rst_le", vif.line_end, 0);

    // First step after release, then pix_ce toggling: 0->1->1->2->2.
    reset = 1'b0;
    tick(1'b1);
    chk("first_x", vif.DrawX, 1);
    chk("first_blank", vif.blank, 1);
    chk("first_fs", vif.frame_start, 0);
    tick(1'b0);
    chk("hold1_x", vif.DrawX, 1);
    tick(1'b1);
    chk("step2_x", vif.DrawX, 2);
    tick(1'b0);
    chk("hold2_x", vif.DrawX, 2);
    chk("hold2_blank", vif.blank, 1);

    // (2,0) -> (799,479): 479*800 + 797 steps.
    run(383997);
    chk("p799_479_x", vif.DrawX, 799);
    chk("p799_479_y", vif.DrawY, 479);
    chk("p799_479_le", vif.line_end, 1);
    chk("p799_479_blank", vif.blank, 0);
    tick(1'b1);
    chk("p0_480_x", vif.DrawX, 0);
    chk("p0_480_y", vif.DrawY, 480);
    chk("p0_480_blank", vif.blank, 0);
    chk("p0_480_le", vif.line_end, 0);

    // (0,480) -> (700,490): inside both sync regions.
    run(8700);
    chk("p700_490_x", vif.DrawX, 700);
    chk("p700_490_y", vif.DrawY, 490);
    chk("p700_490_hs", vif.hs, 0);
    chk("p700_490_vs", vif.vs, 0);

    // One-cycle reset mid-sync.
    reset = 1'b1;
    tick(1'b1);
    chk("midrst_x", vif.DrawX, 0);
    chk("midrst_y", vif.DrawY, 0);
    chk("midrst_hs", vif.hs, 1);
    chk("midrst_vs", vif.vs, 1);
    chk("midrst_blank", vif.blank, 0);
    reset = 1'b0;

    // Horizontal sync edges.
    run(656);
    chk("h656_x", vif.DrawX, 656);
    chk("h656_y", vif.DrawY, 0);
    chk("h656_blank", vif.blank, 0);
    chk("h656_hs", vif.hs, SYNC_DLY ? 1 : 0);
    tick(1'b1);
    chk("h657_hs", vif.hs, 0);
    run(95);
    chk("h752_x", vif.DrawX, 752);
    chk("h752_hs", vif.hs, SYNC_DLY ? 0 : 1);
    tick(1'b1);
    chk("h753_hs", vif.hs, 1);
    run(46);
    chk("h799_x", vif.DrawX, 799);
    chk("h799_le", vif.line_end, 1);

    // Remainder of the frame from reset: 420000 steps in total, no early pulse.
    fs_count = 0;
    for (int i = 0; i < 419200; i++) begin
      tick(1'b1);
      if (vif.frame_start === 1'b1) fs_count++;
    end
    chk("early_fs_count", fs_count, 0);
    tick(1'b1);
    chk("wrap_fs", vif.frame_start, 1);
    chk("wrap_x", vif.DrawX, 0);
    chk("wrap_y", vif.DrawY, 0);

    // One full frame after the first frame_start.
    fs_count = 0;
    vs_low   = 0;
    for (int i = 0; i < 420000; i++) begin
      tick(1'b1);
      if (vif.frame_start === 1'b1) fs_count++;
      if (vif.vs === 1'b0) vs_low++;
    end
    chk("frame_fs_count", fs_count, 1);
    chk("frame_end_fs", vif.frame_start, 1);
    chk("frame_vs_low", vs_low, 1600);

    // Idle cycle clears the pulse and holds position.
    tick(1'b0);
    chk("idle_fs", vif.frame_start, 0);
    chk("idle_x", vif.DrawX, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 vga_clk  input  1  pixel-domain clock; all logic is on its rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 pix_ce  input  1  pixel clock-enable; the raster advances one pixel per cycle with pix_ce=1.
REQ-004 DrawX  output  10  current horizontal position, 0..799.
REQ-005 DrawY  output  10  current vertical position, 0..524.
REQ-006 blank  output  1  1 = visible pixel (DrawX<640 and DrawY<480); 0 = porch/sync/reset.
REQ-007 hs  output  1  horizontal sync, active low.
REQ-008 vs  output  1  vertical sync, active low.
REQ-009 frame_start  output  1  one-cycle pulse when the position becomes (0,0).
REQ-010 line_end  output  1  high while DrawX=799.

Function
REQ-011 Horizontal FSM states are H_ACTIVE (0-639), H_FRONT (640-655), H_SYNC (656-751) and H_BACK (752-799).
REQ-012 Vertical FSM states are V_ACTIVE (0-479), V_FRONT (480-489), V_SYNC (490-491) and V_BACK (492-524).
REQ-013 State transitions occur only on the pix_ce=1 cycle in which the counter crosses a listed boundary; H_BACK goes to H_ACTIVE, and V_BACK goes to V_ACTIVE.
REQ-014 With pix_ce=1, DrawX increments by 1; at 799 it wraps to 0 and DrawY increments in the same cycle.
REQ-015 When DrawY=524 and DrawX=799 with pix_ce=1, both counters wrap to 0 in the same cycle.
REQ-016 With pix_ce=0, all counters, states and level outputs hold, and frame_start is 0.
REQ-017 All outputs are registered and glitch-free; blank, hs, vs, line_end and frame_start are decoded from the next position, so they align with DrawX/DrawY in the same cycle (zero relative lag).
REQ-018 hs=0 exactly when DrawX is in 656..751, and vs=0 exactly when DrawY is in 490..491.
REQ-019 frame_start=1 only in the single cycle after a pix_ce=1 wrap from (799,524) to (0,0).
REQ-020 Counter arithmetic is 10-bit unsigned; no position outside 0..799 x 0..524 is ever produced.
REQ-021 The frame period is exactly 420000 pix_ce=1 cycles.

Reset
REQ-022 While reset=1: DrawX=0, DrawY=0, blank=0, hs=1, vs=1, frame_start=0, line_end=0, and the FSMs are in H_ACTIVE/V_ACTIVE.
REQ-023 Reset takes priority over pix_ce.
REQ-024 Reset asserted mid-frame (including during H_SYNC/V_SYNC) returns all outputs to their REQ-022 values at the next edge.
REQ-025 After reset is released, the first pix_ce=1 cycle produces position (1,0) with blank=1; no frame_start is produced for the reset position.

Configuration
REQ-026 Macro VGA_SYNC_DELAY_EN: when defined, hs and vs are delayed by one additional pix_ce=1 cycle relative to DrawX/DrawY, to match a one-cycle registered colour stage downstream.
REQ-027 With VGA_SYNC_DELAY_EN defined, blank, frame_start and line_end are unaffected, and the delay registers reset to 1.
REQ-028 Without VGA_SYNC_DELAY_EN, hs and vs are zero-lag as in REQ-017.

Verification
REQ-029 Release reset, then hold pix_ce=1 for 656 cycles -> DrawX=656, DrawY=0, hs=0, blank=0; after 96 more cycles -> DrawX=752, hs=1.
REQ-030 Run pix_ce=1 for 420000 cycles after the first frame_start -> exactly one further frame_start, and vs=0 for exactly 1600 cycles.
REQ-031 Toggle pix_ce 1,0,1,0 -> positions advance 0->1->1->2->2; no double steps.
REQ-032 Assert reset for 1 cycle at position (700,490) -> next cycle DrawX=0, DrawY=0, hs=1, vs=1, blank=0.
REQ-033 Drive to (799,479) with pix_ce=1 -> next cycle (0,480) with blank=0 and line_end=0.
REQ-034 Build with VGA_SYNC_DELAY_EN defined -> hs falls one pix_ce=1 cycle after DrawX reaches 656, and blank timing is unchanged.
